// File: rtl/stopwatch_control.sv
// stopwatch_control: key debounce, press-event detection and run/stop/lap FSM for a BCD stopwatch.
// Latency: a clean press changes state and outputs DEBOUNCE_CYCLES+3 clock edges after its first low sample.
// Backpressure: none; key events are pulses, and an event arriving with no matching transition is dropped.
//
// Optional feature macro: STOPWATCH_LAP_EN (lap-hold register and LAP state).
//   Undefined: lap is ignored while running, LAP is unreachable, disp_digits = digits_in.
//
// Ports (stopwatch_control):
//   clock        in   1   system clock, all logic on posedge
//   resetn       in   1   synchronous active-low reset
//   key_start_n  in   1   raw start/stop button, low = pressed
//   key_lap_n    in   1   raw lap/clear button, low = pressed
//   digits_in    in  24   live BCD time {min_h, min_l, s_h, s_l, ms_h, ms_l}
//   count_en     out  1   counter advance enable (registered)
//   count_clr    out  1   counter synchronous clear (registered)
//   disp_digits  out 24   BCD digits to the seven-segment decoders
//   state        out  2   CLEARED=0, RUNNING=1, STOPPED=2, LAP=3

// Per-key synchroniser, debouncer and press-event detector.
// Latency: press pulse is valid in the cycle after the debounced level falls (DEBOUNCE_CYCLES+2 edges).
// Backpressure: none; one pulse per debounced press, release is silent.
//
// Ports (stopwatch_debounce):
//   i_clk      in  1  clock
//   i_resetn   in  1  synchronous active-low reset
//   i_settled  in  1  synchroniser refilled with real samples since reset release
//   i_key_n    in  1  raw key, low = pressed
//   o_press    out 1  one-cycle press event
module stopwatch_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_settled,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_d;
  logic [CW-1:0] r_cnt;
  logic          r_armed;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_sync1    <= i_key_n;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;

      // Count consecutive disagreeing samples; any agreeing sample restarts.
      if (r_sync2 != r_stable) begin
        if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end

      // A key held through reset must be seen released (debounced level high
      // and a real high sample) before any press is honoured. The synchroniser
      // flops reset high, so their first two samples are not trusted.
      if (i_settled && r_stable && r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_press = r_armed & r_stable_d & ~r_stable;

endmodule

module stopwatch_control #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        key_start_n,
  input  logic        key_lap_n,
  input  logic [23:0] digits_in,
  output logic        count_en,
  output logic        count_clr,
  output logic [23:0] disp_digits,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_CLEARED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STOPPED = 2'd2,
    ST_LAP     = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_count_en;
  logic       r_count_clr;
  logic [1:0] r_settle;

  state_t     w_state_nxt;
  logic       w_count_en_nxt;
  logic       w_count_clr_nxt;
  logic       w_start_evt;
  logic       w_lap_raw;
  logic       w_lap_evt;
  logic       w_settled;

  // Two edges after reset release the synchronisers hold real key samples.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_settle <= 2'd0;
    end else if (r_settle != 2'd2) begin
      r_settle <= r_settle + 2'd1;
    end
  end

  assign w_settled = (r_settle == 2'd2);

  stopwatch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_start (
    .i_clk    (clock),
    .i_resetn (resetn),
    .i_settled(w_settled),
    .i_key_n  (key_start_n),
    .o_press  (w_start_evt)
  );

  stopwatch_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_lap (
    .i_clk    (clock),
    .i_resetn (resetn),
    .i_settled(w_settled),
    .i_key_n  (key_lap_n),
    .o_press  (w_lap_raw)
  );

  // Start wins a same-cycle collision; the lap event is discarded.
  assign w_lap_evt = w_lap_raw & ~w_start_evt;

`ifdef STOPWATCH_LAP_EN
  logic        w_hold_load;
  logic [23:0] r_hold;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_count_clr_nxt = 1'b0;
`ifdef STOPWATCH_LAP_EN
    w_hold_load     = 1'b0;
`endif
    case (r_state)
      ST_CLEARED: begin
        if (w_start_evt) w_state_nxt = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (w_start_evt) begin
          w_state_nxt = ST_STOPPED;
        end
`ifdef STOPWATCH_LAP_EN
        else if (w_lap_evt) begin
          w_state_nxt = ST_LAP;
          w_hold_load = 1'b1;
        end
`endif
      end
      ST_STOPPED: begin
        if (w_start_evt) begin
          w_state_nxt = ST_RUNNING;
        end else if (w_lap_evt) begin
          w_state_nxt     = ST_CLEARED;
          w_count_clr_nxt = 1'b1;
        end
      end
      ST_LAP: begin
        if (w_start_evt) begin
          w_state_nxt = ST_STOPPED;
        end else if (w_lap_evt) begin
          w_state_nxt = ST_RUNNING;
        end
      end
    endcase
    w_count_en_nxt = (w_state_nxt == ST_RUNNING) || (w_state_nxt == ST_LAP);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= ST_CLEARED;
      r_count_en  <= 1'b0;
      r_count_clr <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_count_en  <= w_count_en_nxt;
      r_count_clr <= w_count_clr_nxt;
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Hold register only ever captures on the RUNNING->LAP edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_hold <= 24'h000000;
    end else if (w_hold_load) begin
      r_hold <= digits_in;
    end
  end

  assign disp_digits = (r_state == ST_LAP) ? r_hold : digits_in;
`else
  assign disp_digits = digits_in;
`endif

  assign count_en  = r_count_en;
  assign count_clr = r_count_clr;
  assign state     = r_state;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control with DEBOUNCE_CYCLES = 4.
// Latency: a clean press is expected to change state on the 7th edge after its first low sample.
// Backpressure: not applicable; keys are driven directly.
module tb_stopwatch_control;

  logic        clock;
  logic        resetn;
  logic        key_start_n;
  logic        key_lap_n;
  logic [23:0] digits_in;
  logic        count_en;
  logic        count_clr;
  logic [23:0] disp_digits;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  stopwatch_control #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .key_start_n(key_start_n),
    .key_lap_n  (key_lap_n),
    .digits_in  (digits_in),
    .count_en   (count_en),
    .count_clr  (count_clr),
    .disp_digits(disp_digits),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n edges; outputs are then sampled 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clean press of the selected key(s): state must hold for 6 edges and
  // change on the 7th, then the key is released and allowed to settle.
  task automatic press(input string tag, input logic s, input logic l,
                       input logic [1:0] st_before, input logic [1:0] st_after);
    key_start_n = ~s;
    key_lap_n   = ~l;
    tick(6);
    chk({tag, "_before"}, 32'(state), 32'(st_before));
    tick(1);
    chk({tag, "_after"}, 32'(state), 32'(st_after));
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    tick(10);
    chk({tag, "_settled"}, 32'(state), 32'(st_after));
  endtask

  initial begin
    resetn      = 1'b0;
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    digits_in   = 24'h000000;

    // Reset state.
    tick(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count_en", 32'(count_en), 32'd0);
    chk("rst_count_clr", 32'(count_clr), 32'd1);
    chk("rst_disp", 32'(disp_digits), 32'h000000);
    resetn = 1'b1;
    tick(1);
    chk("rst_rel_count_clr", 32'(count_clr), 32'd0);
    chk("rst_rel_state", 32'(state), 32'd0);
    tick(3);

    // Clean start press held 20 cycles: exactly one transition at edge 7.
    key_start_n = 1'b0;
    tick(6);
    chk("lat_edge6_state", 32'(state), 32'd0);
    chk("lat_edge6_en", 32'(count_en), 32'd0);
    tick(1);
    chk("lat_edge7_state", 32'(state), 32'd1);
    chk("lat_edge7_en", 32'(count_en), 32'd1);
    chk("lat_edge7_clr", 32'(count_clr), 32'd0);
    tick(13);
    chk("held_single_event", 32'(state), 32'd1);
    key_start_n = 1'b1;
    tick(10);
    chk("release_no_event", 32'(state), 32'd1);

    // Bouncing start key: 3 low / 1 high x5, then stable low.
    for (int r = 0; r < 5; r++) begin
      key_start_n = 1'b0;
      tick(3);
      key_start_n = 1'b1;
      tick(1);
    end
    chk("bounce_no_change", 32'(state), 32'd1);
    key_start_n = 1'b0;
    tick(6);
    chk("bounce_stable6", 32'(state), 32'd1);
    tick(1);
    chk("bounce_stable7", 32'(state), 32'd2);
    chk("bounce_en_off", 32'(count_en), 32'd0);
    tick(10);
    chk("bounce_one_event", 32'(state), 32'd2);
    key_start_n = 1'b1;
    tick(10);

    // STOPPED -> RUNNING, then lap behaviour.
    press("restart", 1'b1, 1'b0, 2'd2, 2'd1);
    digits_in = 24'h012345;
`ifdef STOPWATCH_LAP_EN
    press("lap1", 1'b0, 1'b1, 2'd1, 2'd3);
    chk("lap1_en", 32'(count_en), 32'd1);
    chk("lap1_disp", 32'(disp_digits), 32'h012345);
    digits_in = 24'h012399;
    tick(1);
    chk("lap1_disp_hold", 32'(disp_digits), 32'h012345);
    press("lap2", 1'b0, 1'b1, 2'd3, 2'd1);
    chk("lap2_disp", 32'(disp_digits), 32'h012399);
    digits_in = 24'h012400;
    tick(1);
    chk("lap2_disp_track", 32'(disp_digits), 32'h012400);
`else
    press("nolap", 1'b0, 1'b1, 2'd1, 2'd1);
    chk("nolap_disp", 32'(disp_digits), 32'h012345);
    digits_in = 24'h012399;
    tick(1);
    chk("nolap_disp_track", 32'(disp_digits), 32'h012399);
`endif

    // Start and lap on the same cycle: start wins.
    digits_in = 24'h055555;
    press("both", 1'b1, 1'b1, 2'd1, 2'd2);
    chk("both_en", 32'(count_en), 32'd0);
    chk("both_disp", 32'(disp_digits), 32'h055555);

    // STOPPED + lap -> CLEARED with a single-cycle clear.
    key_lap_n = 1'b0;
    tick(6);
    chk("clr_edge6_state", 32'(state), 32'd2);
    chk("clr_edge6_clr", 32'(count_clr), 32'd0);
    tick(1);
    chk("clr_edge7_state", 32'(state), 32'd0);
    chk("clr_edge7_clr", 32'(count_clr), 32'd1);
    chk("clr_edge7_en", 32'(count_en), 32'd0);
    tick(1);
    chk("clr_edge8_clr", 32'(count_clr), 32'd0);
    chk("clr_edge8_state", 32'(state), 32'd0);
    key_lap_n = 1'b1;
    tick(10);

    // Lap ignored in CLEARED.
    press("cleared_lap", 1'b0, 1'b1, 2'd0, 2'd0);

    // Key held through reset is not accepted until released and re-pressed.
    key_start_n = 1'b0;
    tick(3);
    resetn = 1'b0;
    tick(2);
    chk("midpress_rst_clr", 32'(count_clr), 32'd1);
    resetn = 1'b1;
    tick(20);
    chk("held_thru_reset", 32'(state), 32'd0);
    chk("held_thru_reset_en", 32'(count_en), 32'd0);
    key_start_n = 1'b1;
    tick(10);
    chk("after_release", 32'(state), 32'd0);
    press("repress", 1'b1, 1'b0, 2'd0, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
